// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl -- address/control sequencer for a direct 2-D convolution.
//
// For every output window the sequencer walks all CH*K*K kernel taps
// (kx fastest, then ky, then channel). Each tap issues one image-RAM and
// kernel-RAM read. The MAC strobes follow one cycle later to match the
// RAM read latency. After the last tap it spends one DRAIN cycle so that
// the final mac_en can land. It then presents the result in OUT until
// downstream accepts it.
//
// Optional feature: define CONV_SEQ_CTRL_PAD_EN for same-padding. In that
// mode the output map is IMG_W x IMG_H. Taps that fall outside the image
// are still issued, but with img_rd=0 and img_addr=0, and tap_pad marks
// them for the MAC. Without the macro the block does valid convolution
// and contains no padding logic.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (abandons any run)
//   en         start pulse, only looked at in IDLE
//   out_ready  downstream accepts the presented result
//   img_rd     image RAM read strobe
//   img_addr   image RAM address
//   ker_addr   kernel RAM address (qualified by the RUN tap cycle)
//   mac_en     MAC consumes RAM data this cycle
//   mac_clr    MAC loads instead of accumulating (first tap of a window)
//   tap_pad    MAC substitutes zero for image data this cycle
//   out_valid  result available; out_addr is the output map index
//   busy       run in progress (any state but IDLE)
//   done       one-cycle pulse after the last result is accepted
module conv_seq_ctrl #(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 3,
    parameter int CH     = 1,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              out_ready,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] ker_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              tap_pad,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

`ifdef CONV_SEQ_CTRL_PAD_EN
    localparam int OW  = IMG_W;
    localparam int OH  = IMG_H;
    localparam int PAD = (K - 1) / 2;
`else
    localparam int OW  = IMG_W - K + 1;
    localparam int OH  = IMG_H - K + 1;
`endif

    localparam int KW = $clog2(K + 1);
    localparam int CW = $clog2(CH + 1);
    localparam int XW = $clog2(OW + 1);
    localparam int YW = $clog2(OH + 1);

    localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CH - 1);
    localparam logic [XW-1:0] OX_LAST = XW'(OW - 1);
    localparam logic [YW-1:0] OY_LAST = YW'(OH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [KW-1:0] kx, ky;
    logic [CW-1:0] c;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;

    logic tap_vld_p0;
    logic tap_first_p0;
    logic tap_pad_p0;
    logic tap_vld_p1;
    logic tap_first_p1;
    logic tap_pad_p1;

    logic last_tap;
    logic last_win;
    logic in_img;
    logic [ADDR_W-1:0] tap_img_addr;
    logic [ADDR_W-1:0] tap_ker_addr;
    logic [ADDR_W-1:0] win_addr;

    // Row-major linear image address of channel/row/column.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [31:0] ch_i,
                                                   input logic [31:0] row,
                                                   input logic [31:0] col);
        logic [31:0] a;
        a = (ch_i * IMG_H + row) * IMG_W + col;
        return ADDR_W'(a);
    endfunction

    assign last_tap = (kx == K_LAST) && (ky == K_LAST) && (c == C_LAST);
    assign last_win = (ox == OX_LAST) && (oy == OY_LAST);

    assign tap_ker_addr = ADDR_W'((32'(c) * K + 32'(ky)) * K + 32'(kx));
    assign win_addr     = ADDR_W'(32'(oy) * OW + 32'(ox));

`ifdef CONV_SEQ_CTRL_PAD_EN
    // Window origin sits PAD pixels up/left of the output pixel, so the
    // image coordinate can go negative; work in signed 32-bit.
    logic signed [31:0] ix_s, iy_s;
    assign ix_s   = $signed(32'(ox)) + $signed(32'(kx)) - PAD;
    assign iy_s   = $signed(32'(oy)) + $signed(32'(ky)) - PAD;
    assign in_img = (ix_s >= 0) && (ix_s < IMG_W) && (iy_s >= 0) && (iy_s < IMG_H);
    assign tap_img_addr = in_img ? lin_addr(32'(c), $unsigned(iy_s), $unsigned(ix_s))
                                 : '0;
`else
    assign in_img       = 1'b1;
    assign tap_img_addr = lin_addr(32'(c), 32'(oy) + 32'(ky), 32'(ox) + 32'(kx));
`endif

    assign tap_vld_p0   = (state == S_RUN);
    assign tap_first_p0 = tap_vld_p0 && (kx == '0) && (ky == '0) && (c == '0);
    assign tap_pad_p0   = tap_vld_p0 && !in_img;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and outputs
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        img_rd    = 1'b0;
        img_addr  = '0;
        ker_addr  = '0;
        out_valid = 1'b0;
        out_addr  = '0;
        mac_en    = tap_vld_p1;
        mac_clr   = tap_first_p1;
        tap_pad   = tap_pad_p1;
        case (state)
            S_IDLE: begin
                if (en) state_nx = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                img_rd   = in_img;
                img_addr = tap_img_addr;
                ker_addr = tap_ker_addr;
                if (last_tap) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = win_addr;
                if (out_ready) state_nx = last_win ? S_DONE : S_RUN;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Tap and window counters; the tap counters wrap to zero on the last
    // tap, so each window starts clean without an explicit clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            kx <= '0;
            ky <= '0;
            c  <= '0;
            ox <= '0;
            oy <= '0;
        end else if (state == S_RUN) begin
            if (kx == K_LAST) begin
                kx <= '0;
                if (ky == K_LAST) begin
                    ky <= '0;
                    c  <= (c == C_LAST) ? '0 : c + CW'(1);
                end else begin
                    ky <= ky + KW'(1);
                end
            end else begin
                kx <= kx + KW'(1);
            end
        end else if (state == S_OUT && out_ready) begin
            if (ox == OX_LAST) begin
                ox <= '0;
                oy <= (oy == OY_LAST) ? '0 : oy + YW'(1);
            end else begin
                ox <= ox + XW'(1);
            end
        end
    end

    // ---- p0 -> p1: tap issue to MAC strobe (one-cycle RAM latency) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_vld_p1   <= 1'b0;
            tap_first_p1 <= 1'b0;
            tap_pad_p1   <= 1'b0;
        end else begin
            tap_vld_p1   <= tap_vld_p0;
            tap_first_p1 <= tap_first_p0;
            tap_pad_p1   <= tap_pad_p0;
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: a CH=1 and a CH=2 instance run one at
// a time. Expected taps and results are queued when a run is started, and
// popped as the DUT raises mac_en / completes an output handshake.
module tb_conv_seq_ctrl;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int K     = 3;
`ifdef CONV_SEQ_CTRL_PAD_EN
    localparam int OW = IMG_W;
    localparam int OH = IMG_H;
    localparam int PV = (K - 1) / 2;
`else
    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam int PV = 0;
`endif

    typedef struct packed {
        logic [15:0] ia;
        logic [15:0] ka;
        logic        clr;
        logic        pad;
        logic        rd;
    } tap_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] hs;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        out_ready = 1'b1;
    logic [1:0]  en_w = '0;
    logic [1:0]  img_rd_w, mac_en_w, mac_clr_w, tap_pad_w, out_valid_w, busy_w, done_w;
    logic [15:0] img_addr_w [2];
    logic [15:0] ker_addr_w [2];
    logic [15:0] out_addr_w [2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int exp_done = -1;
    int done_cnt = 0;
    bit done_seen = 1'b0;
    bit mon_on = 1'b0;

    tap_t q_tap[$];
    out_t q_out[$];

    logic [15:0] ps_ia [2];
    logic [15:0] ps_ka [2];
    logic        ps_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_seq_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CH(1), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .en(en_w[0]), .out_ready(out_ready),
        .img_rd(img_rd_w[0]), .img_addr(img_addr_w[0]), .ker_addr(ker_addr_w[0]),
        .mac_en(mac_en_w[0]), .mac_clr(mac_clr_w[0]), .tap_pad(tap_pad_w[0]),
        .out_valid(out_valid_w[0]), .out_addr(out_addr_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    conv_seq_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CH(2), .ADDR_W(16)) dut2 (
        .clk(clk), .reset(reset), .en(en_w[1]), .out_ready(out_ready),
        .img_rd(img_rd_w[1]), .img_addr(img_addr_w[1]), .ker_addr(ker_addr_w[1]),
        .mac_en(mac_en_w[1]), .mac_clr(mac_clr_w[1]), .tap_pad(tap_pad_w[1]),
        .out_valid(out_valid_w[1]), .out_addr(out_addr_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, "_strobes"}, {busy_w[i], done_w[i], img_rd_w[i], mac_en_w[i],
                                  mac_clr_w[i], tap_pad_w[i], out_valid_w[i]}, 0);
        check({tag, "_addrs"}, {img_addr_w[i], ker_addr_w[i], out_addr_w[i]}, 0);
    endtask

    // Monitor: everything observed on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                tap_t r;
                out_t o;
                int rel;
                rel = cyc - t0;
                if (mac_en_w[i]) begin
                    if (q_tap.size() == 0) begin
                        check("tap_extra", 1, 0);
                    end else begin
                        r = q_tap.pop_front();
                        check("img_addr", ps_ia[i], r.ia);
                        check("ker_addr", ps_ka[i], r.ka);
                        check("img_rd", ps_rd[i], r.rd);
                        check("mac_clr", mac_clr_w[i], r.clr);
                        check("tap_pad", tap_pad_w[i], r.pad);
                    end
                end else begin
                    check("stray_clr_pad", {mac_clr_w[i], tap_pad_w[i]}, 0);
                end
                if (out_valid_w[i]) begin
                    check("rd_in_out", img_rd_w[i], 0);
                    if (q_out.size() == 0) begin
                        check("out_extra", 1, 0);
                    end else begin
                        o = q_out[0];
                        check("out_addr", out_addr_w[i], o.addr);
                        if (out_ready) begin
                            check("hs_cycle", rel, o.hs);
                            void'(q_out.pop_front());
                        end
                    end
                end
                if (done_w[i]) begin
                    check("done_cycle", rel, exp_done);
                    check("busy_at_done", busy_w[i], 1);
                    done_cnt++;
                    done_seen = 1'b1;
                end
                ps_ia[i] = img_addr_w[i];
                ps_ka[i] = ker_addr_w[i];
                ps_rd[i] = img_rd_w[i];
            end
        end
    end

    // Queue the whole expected run for instance inst (CH = inst+1).
    task automatic push_model(input int inst, input int stall);
        int ch, n, w;
        tap_t r;
        out_t o;
        ch = inst + 1;
        n  = ch * K * K;
        q_tap.delete();
        q_out.delete();
        w = 0;
        for (int oy = 0; oy < OH; oy++) begin
            for (int ox = 0; ox < OW; ox++) begin
                for (int c = 0; c < ch; c++) begin
                    for (int ky = 0; ky < K; ky++) begin
                        for (int kx = 0; kx < K; kx++) begin
                            int x, y;
                            bit in;
                            x = ox - PV + kx;
                            y = oy - PV + ky;
                            in = (x >= 0) && (x < IMG_W) && (y >= 0) && (y < IMG_H);
                            r.ia  = in ? 16'((c * IMG_H + y) * IMG_W + x) : 16'd0;
                            r.ka  = 16'((c * K + ky) * K + kx);
                            r.clr = (c == 0) && (ky == 0) && (kx == 0);
                            r.pad = !in;
                            r.rd  = in;
                            q_tap.push_back(r);
                        end
                    end
                end
                o.addr = 32'(oy * OW + ox);
                o.hs   = 32'((w + 1) * (n + 2) + ((stall != 0 && w >= 1) ? 5 : 0));
                q_out.push_back(o);
                w++;
            end
        end
        exp_done = OW * OH * (n + 2) + 1 + ((stall != 0) ? 5 : 0);
        done_cnt = 0;
        done_seen = 1'b0;
    endtask

    // Full run with an en pulse at relative cycle 0; optional 5-cycle
    // out_ready stall at the first OUT cycle of window 1. Spurious en
    // pulses are injected mid-run and must be ignored.
    task automatic run_case(input int inst, input int stall);
        int n, budget, rel;
        n = (inst + 1) * K * K;
        push_model(inst, stall);
        budget = exp_done + 30;
        @(posedge clk); #1;
        t0 = cyc;
        out_ready = 1'b1;
        en_w[inst] = 1'b1;
        for (int k = 0; k < budget && !done_seen; k++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            en_w = '0;
            if (rel == 5 || rel == n + 2) en_w[inst] = 1'b1;
            out_ready = !(stall != 0 && rel >= 2 * (n + 2) && rel < 2 * (n + 2) + 5);
        end
        en_w = '0;
        out_ready = 1'b1;
        check("run_timeout", done_seen, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("taps_left", q_tap.size(), 0);
        check("outs_left", q_out.size(), 0);
        check("done_count", done_cnt, 1);
        check_idle(inst, "post_run");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "in_reset0");
        check_idle(1, "in_reset1");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle(0, "after_reset0");
        check_idle(1, "after_reset1");
        mon_on = 1'b1;

        run_case(0, 0);
        run_case(0, 1);
        run_case(1, 0);

        // Reset in the middle of RUN, then restart from scratch.
        push_model(0, 0);
        exp_done = -1;
        @(posedge clk); #1;
        t0 = cyc;
        en_w[0] = 1'b1;
        @(posedge clk); #1;
        en_w[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q_tap.delete();
        q_out.delete();
        @(negedge clk);
        check_idle(0, "mid_run_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_no_done", done_cnt, 0);
        check_idle(0, "reset_idle");

        run_case(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
